// File: rtl/model_vector_integer_stream_driver.sv
// Element-stream initiator: streams operand pairs to a vector unit one at a time and buffers the returned results.
// Optional watchdog abort when MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN is defined.
module model_vector_integer_stream_driver #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_enable_i,
    input  logic                    load_select_i,
    input  logic [CONTROL_SIZE-1:0] load_address_i,
    input  logic [DATA_SIZE-1:0]    load_data_i,
    input  logic [DATA_SIZE-1:0]    size_in_i,
    input  logic                    go_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    input  logic [CONTROL_SIZE-1:0] result_address_i,
    output logic [DATA_SIZE-1:0]    result_data_o,
    output logic                    unit_start_o,
    input  logic                    unit_ready_i,
    output logic                    unit_data_a_enable_o,
    output logic                    unit_data_b_enable_o,
    output logic [DATA_SIZE-1:0]    unit_data_a_o,
    output logic [DATA_SIZE-1:0]    unit_data_b_o,
    output logic [DATA_SIZE-1:0]    unit_size_o,
    input  logic                    unit_data_out_enable_i,
    input  logic [DATA_SIZE-1:0]    unit_data_out_i
);
    localparam int DEPTH = 1 << CONTROL_SIZE;
    localparam int LW    = CONTROL_SIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ISSUE,
        S_WAIT_RESULT,
        S_WAIT_READY
    } state_t;

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] idx_q, idx_d;
    logic [LW-1:0]           len_q, len_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_SIZE-1:0]    result_data_q;

    logic [DATA_SIZE-1:0]    buf_a   [DEPTH];
    logic [DATA_SIZE-1:0]    buf_b   [DEPTH];
    logic [DATA_SIZE-1:0]    buf_res [DEPTH];

    logic [LW-1:0]           size_clamped;
    logic                    last_elem;
    logic                    capture;

    assign size_clamped = (size_in_i > DATA_SIZE'(DEPTH)) ? LW'(DEPTH) : size_in_i[LW-1:0];
    assign last_elem    = ({1'b0, idx_q} == (len_q - LW'(1)));
    assign capture      = (state_q == S_WAIT_RESULT) && unit_data_out_enable_i;

`ifdef MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;
    logic        waiting;
    logic        wdog_fire;

    assign waiting   = (state_q == S_WAIT_RESULT) || (state_q == S_WAIT_READY);
    // Fires on the cycle whose increment would bring the count to 0xFFFF.
    assign wdog_fire = waiting && (wdog_q == 16'hFFFE);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (go_i) begin
`ifdef MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (size_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = size_clamped;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT_RESULT;
            S_WAIT_RESULT: begin
                if (unit_data_out_enable_i) begin
                    if (last_elem) begin
                        // READY together with the final element skips WAIT_READY.
                        if (unit_ready_i) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            len_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT_READY;
                        end
                    end else begin
                        idx_d   = idx_q + CONTROL_SIZE'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_WAIT_READY: begin
                if (unit_ready_i) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    len_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN
        // Real progress on the expiry cycle wins over the abort.
        if (wdog_fire && (state_d == state_q)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            len_d   = '0;
            state_d = S_IDLE;
        end
        wdog_d = (waiting && (state_d == state_q)) ? wdog_q + 16'd1 : 16'd0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_data_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_data_q <= buf_res[result_address_i];
        end
    end

`ifdef MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    // Buffers carry no reset; their contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (load_enable_i && (state_q == S_IDLE)) begin
            if (load_select_i) begin
                buf_b[load_address_i] <= load_data_i;
            end else begin
                buf_a[load_address_i] <= load_data_i;
            end
        end
        if (capture) begin
            buf_res[idx_q] <= unit_data_out_i;
        end
    end

    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign result_data_o        = result_data_q;
    assign unit_start_o         = (state_q == S_START);
    assign unit_data_a_enable_o = (state_q == S_ISSUE);
    assign unit_data_b_enable_o = (state_q == S_ISSUE);
    assign unit_data_a_o        = (state_q == S_ISSUE) ? buf_a[idx_q] : '0;
    assign unit_data_b_o        = (state_q == S_ISSUE) ? buf_b[idx_q] : '0;
    assign unit_size_o          = {{(DATA_SIZE-LW){1'b0}}, len_q};

endmodule

// File: tb/tb_model_vector_integer_stream_driver.sv
// Bench: randomized integer-divide vector-unit responder plus a reference model of operand
// buffers and expected quotients; directed steps in one initial block.
`timescale 1ns/1ps
module tb_model_vector_integer_stream_driver;
    localparam int DW    = 64;
    localparam int CW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, load_en, load_sel, go;
    logic [CW-1:0] load_addr, res_addr;
    logic [DW-1:0] load_data, size_in;
    logic          busy, done, error, unit_start, unit_ready, en_a, en_b, unit_oe;
    logic [DW-1:0] res_data, unit_a, unit_b, unit_size, unit_out;

    model_vector_integer_stream_driver #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .load_enable_i          (load_en),
        .load_select_i          (load_sel),
        .load_address_i         (load_addr),
        .load_data_i            (load_data),
        .size_in_i              (size_in),
        .go_i                   (go),
        .busy_o                 (busy),
        .done_o                 (done),
        .error_o                (error),
        .result_address_i       (res_addr),
        .result_data_o          (res_data),
        .unit_start_o           (unit_start),
        .unit_ready_i           (unit_ready),
        .unit_data_a_enable_o   (en_a),
        .unit_data_b_enable_o   (en_b),
        .unit_data_a_o          (unit_a),
        .unit_data_b_o          (unit_b),
        .unit_size_o            (unit_size),
        .unit_data_out_enable_i (unit_oe),
        .unit_data_out_i        (unit_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] ref_a [DEPTH];
    logic [DW-1:0] ref_b [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: written only here, read by the main sequence via base snapshots.
    int starts = 0, dones = 0, pairs = 0, busy_cyc = 0;
    logic [DW-1:0] iss_a[$], iss_b[$];
    int b_starts, b_dones, b_pairs, b_busy, b_iss;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (unit_start) starts++;
            if (done) dones++;
            if (busy) busy_cyc++;
            if (en_a || en_b) begin
                pairs++;
                iss_a.push_back(unit_a);
                iss_b.push_back(unit_b);
            end
        end
    end

    // Vector unit: integer divider with random latency, random READY placement,
    // spurious READY before the last result and spurious DATA_OUT_ENABLE while idle.
    logic          silent = 1'b0;
    logic          pend = 1'b0, rdy_pend = 1'b0;
    int            dly, rdy_dly, u_size, u_cnt;
    logic [DW-1:0] pa, pb;

    initial begin
        unit_ready = 1'b0;
        unit_oe    = 1'b0;
        unit_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            unit_ready = 1'b0;
            unit_oe    = 1'b0;
            if (rst_n !== 1'b1) begin
                pend     = 1'b0;
                rdy_pend = 1'b0;
            end else begin
                if (unit_start) begin
                    u_size = int'(unit_size);
                    u_cnt  = 0;
                end
                if (silent) begin
                    pend = 1'b0;
                end else if (en_a && en_b) begin
                    pa   = unit_a;
                    pb   = unit_b;
                    pend = 1'b1;
                    dly  = $urandom_range(0, 3);
                end else if (pend) begin
                    if (dly == 0) begin
                        unit_oe  = 1'b1;
                        unit_out = pa / pb;
                        pend     = 1'b0;
                        u_cnt++;
                        if (u_cnt == u_size) begin
                            rdy_dly = $urandom_range(0, 3);
                            if (rdy_dly == 0) unit_ready = 1'b1;
                            else rdy_pend = 1'b1;
                        end
                    end else begin
                        dly--;
                        if ($urandom_range(0, 3) == 0) unit_ready = 1'b1;
                    end
                end else if (rdy_pend) begin
                    rdy_dly--;
                    if (rdy_dly == 0) begin
                        unit_ready = 1'b1;
                        rdy_pend   = 1'b0;
                    end
                end else if (!busy && $urandom_range(0, 7) == 0) begin
                    unit_oe  = 1'b1;
                    unit_out = 64'hDEAD_BEEF_0BAD_F00D;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

    task automatic snap();
        b_starts = starts;
        b_dones  = dones;
        b_pairs  = pairs;
        b_busy   = busy_cyc;
        b_iss    = iss_a.size();
    endtask

    task automatic load(input logic sel, input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = CW'(addr);
        load_data = data;
        if (sel) ref_b[addr] = data;
        else ref_a[addr] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic fill_random();
        logic [DW-1:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            load(1'b0, i, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) b = {32'h0, $urandom} | 64'h1;
            else b = 64'($urandom_range(1, 50));
            load(1'b1, i, b);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_ustart"}, unit_start, 0);
        check({tag, "_en"}, {en_a, en_b}, 0);
        check({tag, "_ua"}, unit_a, 0);
        check({tag, "_ub"}, unit_b, 0);
        check({tag, "_usize"}, unit_size, 0);
        check({tag, "_rdata"}, res_data, 0);
    endtask

    task automatic start_op(input logic [DW-1:0] size, input string tag, output int n);
        n = (size > DEPTH) ? DEPTH : int'(size);
        snap();
        @(negedge clk);
        size_in = size;
        go      = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check({tag, "_start"}, unit_start, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_usize"}, unit_size, 64'(n));
        check({tag, "_err_clr"}, error, 0);
        check({tag, "_no_en_in_start"}, en_a | en_b, 0);
        @(negedge clk);
        check({tag, "_first_en"}, {en_a, en_b}, 2'b11);
        check({tag, "_start_1cyc"}, unit_start, 0);
    endtask

    task automatic finish_op(input int n, input string tag);
        int cyc = 0;
        while (cyc < 3000 && !done) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_clr"}, busy, 0);
        repeat (2) @(negedge clk);
        check({tag, "_n_done"}, dones - b_dones, 1);
        check({tag, "_n_start"}, starts - b_starts, 1);
        check({tag, "_n_pairs"}, pairs - b_pairs, 64'(n));
        for (int i = 0; i < n; i++) begin
            if (b_iss + i < iss_a.size()) begin
                check($sformatf("%s_iss_a%0d", tag, i), iss_a[b_iss + i], ref_a[i]);
                check($sformatf("%s_iss_b%0d", tag, i), iss_b[b_iss + i], ref_b[i]);
            end
        end
        for (int i = 0; i < n; i++) begin
            res_addr = CW'(i);
            @(negedge clk);
            check($sformatf("%s_res%0d", tag, i), res_data, ref_a[i] / ref_b[i]);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] size, input string tag);
        int n;
        start_op(size, tag, n);
        finish_op(n, tag);
    endtask

    initial begin
        int n, seen, cyc;
        rst_n = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
        size_in = '0; go = 1'b0; res_addr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Divider example: 100/10, 81/9, 7/2
        load(1'b0, 0, 100); load(1'b0, 1, 81); load(1'b0, 2, 7);
        load(1'b1, 0, 10);  load(1'b1, 1, 9);  load(1'b1, 2, 2);
        run_op(3, "div3");
        res_addr = 0; @(negedge clk); check("div3_q0", res_data, 10);
        res_addr = 1; @(negedge clk); check("div3_q1", res_data, 9);
        res_addr = 2; @(negedge clk); check("div3_q2", res_data, 3);

        // Zero length: DONE next cycle only
        snap();
        @(negedge clk); size_in = 0; go = 1'b1;
        @(negedge clk); go = 1'b0;
        check("zero_done", done, 1);
        check("zero_ustart", unit_start, 0);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_1cyc", done, 0);
        repeat (3) @(negedge clk);
        check("zero_n_start", starts - b_starts, 0);
        check("zero_n_pairs", pairs - b_pairs, 0);
        check("zero_n_busy", busy_cyc - b_busy, 0);
        check("zero_n_done", dones - b_dones, 1);

        // Length clamped to buffer depth
        fill_random();
        run_op(40, "sz40");
        run_op(64'h8000_0000_0000_0002, "szhuge");

        // GO and LOAD while busy are ignored
        fill_random();
        start_op(4, "busy", n);
        @(negedge clk);
        go = 1'b1; size_in = 7;
        load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = ~ref_a[0];
        @(negedge clk);
        go = 1'b0; load_en = 1'b0;
        finish_op(n, "busy");
        run_op(1, "busy_a0");

        for (int r = 0; r < 5; r++) begin
            fill_random();
            run_op(64'($urandom_range(1, 20)), $sformatf("rnd%0d", r));
        end

        // Reset while element 2 of 4 is issued
        fill_random();
        start_op(4, "rst", n);
        seen = 1;
        for (int k = 0; k < 400 && seen < 2; k++) begin
            @(negedge clk);
            if (en_a && en_b) seen++;
        end
        check("rst_reached_elem2", seen, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        run_op(4, "post_rst");

`ifdef MODEL_VECTOR_STREAM_DRIVER_TIMEOUT_EN
        silent = 1'b1;
        start_op(2, "wdog", n);
        cyc = 2;
        while (cyc < 70000 && !done) begin
            @(negedge clk);
            cyc++;
        end
        check("wdog_done", done, 1);
        check("wdog_latency", cyc, 65538);
        check("wdog_error", error, 1);
        check("wdog_busy", busy, 0);
        silent = 1'b0;
        repeat (2) @(negedge clk);
        check("wdog_error_sticky", error, 1);
        fill_random();
        run_op(3, "after_wdog");
        check("after_wdog_error", error, 0);
`else
        cyc = 0;
        check("error_tied", error, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
